// File: rtl/nios2_qsys_ram_pkg.sv
// Shared types and constants for the Nios II tightly-coupled RAM burst agent.
package nios2_qsys_ram_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned BURST_W_DFLT = 4;

    // Largest legal Avalon burst for a given burstcount width.
    function automatic int unsigned burst_max(input int unsigned bw);
        return 32'd1 << (bw - 32'd1);
    endfunction

endpackage

// File: rtl/nios2_qsys_ram_rsp_pipe.sv
// Two-stage valid/error pipe that lines read responses up with the RAM's registered q output.
module nios2_qsys_ram_rsp_pipe
    import nios2_qsys_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_i,
    input  logic              err_i,
    input  logic [DATA_W-1:0] ram_readdata_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] readdata_o,
    output logic [1:0]        resp_o
);

    logic              v1_q;
    logic              e1_q;
    logic              v2_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        resp_q;

    // Stage 1 tracks the RAM address register; stage 2 captures q alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q   <= 1'b0;
            e1_q   <= 1'b0;
            v2_q   <= 1'b0;
            data_q <= '0;
            resp_q <= RESP_OKAY;
        end else begin
            v1_q <= issue_i;
            e1_q <= err_i;
            v2_q <= v1_q;
            if (v1_q) begin
                data_q <= e1_q ? '0 : ram_readdata_i;
                resp_q <= e1_q ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign valid_o    = v2_q;
    assign readdata_o = data_q;
    assign resp_o     = resp_q;

endmodule

// File: rtl/nios2_qsys_ram_burst_agent.sv
// Avalon-MM burst slave agent in front of the single-port on-chip RAM.
// Optional NIOS2_QSYS_RAM_AGENT_BOUNDS_CHECK_EN flags beats at or above DEPTH as SLVERR.
module nios2_qsys_ram_burst_agent
    import nios2_qsys_ram_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 2560,
    parameter int unsigned BURST_W = BURST_W_DFLT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic [BURST_W-1:0]    avs_burstcount,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    output logic [1:0]            avs_response,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata
);

    localparam int unsigned MAX_BEATS = burst_max(BURST_W);

    if (DEPTH > (32'd1 << ADDR_W)) begin : g_depth_chk
        $error("DEPTH does not fit in the ADDR_W address space");
    end

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BURST_W-1:0] beats_q, beats_d;
    logic [BURST_W-1:0] req_beats_c;
    logic [ADDR_W-1:0]  beat_addr_c;
    logic               beat_c;
    logic               is_wr_c;
    logic               oob_c;
    logic               rd_issue_c;

    // Burstcount of 0 means one beat; oversize counts clamp to the legal maximum.
    always_comb begin
        req_beats_c = avs_burstcount;
        if (avs_burstcount == '0) begin
            req_beats_c = BURST_W'(1);
        end else if (32'(avs_burstcount) > MAX_BEATS) begin
            req_beats_c = BURST_W'(MAX_BEATS);
        end
    end

    assign beat_addr_c = (state_q == IDLE) ? avs_address : addr_q;

`ifdef NIOS2_QSYS_RAM_AGENT_BOUNDS_CHECK_EN
    assign oob_c = (32'(beat_addr_c) >= DEPTH);
`else
    assign oob_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
        end
    end

    // One RAM beat per cycle; write wins when read and write arrive together.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        beat_c  = 1'b0;
        is_wr_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (avs_write || avs_read) begin
                    beat_c  = 1'b1;
                    is_wr_c = avs_write;
                    addr_d  = avs_address + ADDR_W'(1);
                    beats_d = req_beats_c - BURST_W'(1);
                    if (req_beats_c > BURST_W'(1)) begin
                        state_d = avs_write ? WR_BURST : RD_BURST;
                    end
                end
            end
            RD_BURST: begin
                beat_c  = 1'b1;
                addr_d  = addr_q + ADDR_W'(1);
                beats_d = beats_q - BURST_W'(1);
                if (beats_q == BURST_W'(1)) begin
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                if (avs_write) begin
                    beat_c  = 1'b1;
                    is_wr_c = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    beats_d = beats_q - BURST_W'(1);
                    if (beats_q == BURST_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_address     = beat_addr_c;
    assign ram_chipselect  = beat_c & ~oob_c & ~reset;
    assign ram_write       = is_wr_c & ~oob_c & ~reset;
    assign ram_byteenable  = is_wr_c ? avs_byteenable : '1;
    assign ram_writedata   = avs_writedata;
    assign ram_clken       = ~reset;
    assign avs_waitrequest = reset | (state_q == RD_BURST);
    assign rd_issue_c      = beat_c & ~is_wr_c & ~reset;

    nios2_qsys_ram_rsp_pipe #(
        .DATA_W (DATA_W)
    ) u_rsp_pipe (
        .clk            (clk),
        .reset          (reset),
        .issue_i        (rd_issue_c),
        .err_i          (oob_c),
        .ram_readdata_i (ram_readdata),
        .valid_o        (avs_readdatavalid),
        .readdata_o     (avs_readdata),
        .resp_o         (avs_response)
    );

endmodule

// File: tb/tb_nios2_qsys_ram_burst_agent.sv
// Directed bench for the RAM burst agent with a RAM model and a read-response scoreboard.
module tb_nios2_qsys_ram_burst_agent;

`ifdef NIOS2_QSYS_RAM_AGENT_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] c;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] avs_address;
    logic [3:0]  avs_burstcount;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [1:0]  avs_response;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata;

    logic [31:0] mem   [4096];
    logic [31:0] model [4096];
    logic [31:0] cyc    = 32'd0;
    int          wr_cnt = 0;
    rsp_t        exp_q[$];
    rsp_t        obs_q[$];
    int          nxt    = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    nios2_qsys_ram_burst_agent dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_burstcount    (avs_burstcount),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_response      (avs_response),
        .ram_address       (ram_address),
        .ram_byteenable    (ram_byteenable),
        .ram_chipselect    (ram_chipselect),
        .ram_write         (ram_write),
        .ram_writedata     (ram_writedata),
        .ram_clken         (ram_clken),
        .ram_readdata      (ram_readdata)
    );

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Single-port RAM with registered address: q reflects the address of the previous cycle.
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
                end
                wr_cnt <= wr_cnt + 1;
            end
            ram_readdata <= mem[ram_address];
        end
    end

    always @(negedge clk) begin
        if (avs_readdatavalid === 1'b1) obs_q.push_back('{avs_readdata, avs_response, cyc});
    end

    function automatic logic oob(input logic [11:0] a);
        return BCHK && (32'(a) >= 32'd2560);
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write burst of n beats (data d0+i); optional idle cycle after gap_after beats.
    task automatic wr(input logic [11:0] a, input int n, input logic [31:0] d0,
                      input logic [3:0] be, input int gap_after);
        int          base;
        int          n_ok;
        logic [11:0] ba;
        logic [31:0] d;
        base = wr_cnt;
        n_ok = 0;
        for (int i = 0; i < n; i++) begin
            ba = a + 12'(i);
            d  = d0 + 32'(i);
            avs_write      = 1'b1;
            avs_address    = a;
            avs_burstcount = 4'(n);
            avs_writedata  = d;
            avs_byteenable = be;
            #1;
            chk("wr_wait", 32'(avs_waitrequest), 32'd0);
            chk("wr_addr", 32'(ram_address), 32'(ba));
            if (!oob(ba)) begin
                n_ok++;
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[ba][8*b +: 8] = d[8*b +: 8];
                end
            end
            tick();
            if (i + 1 == gap_after) begin
                avs_write = 1'b0;
                #1;
                chk("wr_gap_cs", 32'(ram_chipselect), 32'd0);
                tick();
            end
        end
        avs_write = 1'b0;
        chk("wr_count", 32'(wr_cnt - base), 32'(n_ok));
    endtask

    // Read burst of n beats; pushes one expected response per beat with its due cycle.
    task automatic rd(input logic [11:0] a, input int n);
        logic [11:0] ba;
        avs_address    = a;
        avs_burstcount = 4'(n);
        avs_read       = 1'b1;
        avs_write      = 1'b0;
        for (int i = 0; i < n; i++) begin
            ba = a + 12'(i);
            #1;
            chk("rd_addr", 32'(ram_address), 32'(ba));
            if (i > 0) chk("rd_wait", 32'(avs_waitrequest), 32'd1);
            exp_q.push_back('{oob(ba) ? 32'd0 : model[ba], oob(ba) ? 2'b10 : 2'b00, cyc + 32'd2});
            tick();
            avs_read = 1'b0;
        end
        chk("rd_wait_end", 32'(avs_waitrequest), 32'd0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (obs_q.size() < exp_q.size() && k < 40) begin
            tick();
            k++;
        end
        repeat (4) tick();
        chk("rsp_count", 32'(obs_q.size()), 32'(exp_q.size()));
        while (nxt < exp_q.size()) begin
            if (nxt < obs_q.size()) begin
                chk("rsp_data", obs_q[nxt].d, exp_q[nxt].d);
                chk("rsp_resp", 32'(obs_q[nxt].r), 32'(exp_q[nxt].r));
                chk("rsp_cycle", obs_q[nxt].c, exp_q[nxt].c);
            end
            nxt++;
        end
        if (obs_q.size() > nxt) nxt = obs_q.size();
    endtask

    initial begin
        reset          = 1'b1;
        avs_address    = 12'h000;
        avs_burstcount = 4'd1;
        avs_read       = 1'b1;
        avs_write      = 1'b0;
        avs_writedata  = 32'd0;
        avs_byteenable = 4'hF;
        tick();
        chk("rst_wait", 32'(avs_waitrequest), 32'd1);
        chk("rst_clken", 32'(ram_clken), 32'd0);
        chk("rst_cs", 32'(ram_chipselect), 32'd0);
        chk("rst_valid", 32'(avs_readdatavalid), 32'd0);
        chk("rst_data", avs_readdata, 32'd0);
        chk("rst_resp", 32'(avs_response), 32'd0);
        tick();
        reset    = 1'b0;
        avs_read = 1'b0;
        #1;
        chk("idle_wait", 32'(avs_waitrequest), 32'd0);
        chk("idle_clken", 32'(ram_clken), 32'd1);

        // Single write then read, plus back-to-back single reads.
        wr(12'h010, 1, 32'hDEADBEEF, 4'hF, 0);
        rd(12'h010, 1);
        wr(12'h011, 2, 32'h5A5A0011, 4'hF, 0);
        rd(12'h011, 1);
        rd(12'h012, 1);
        rd(12'h010, 1);
        drain();

        // Byte-lane write merge.
        wr(12'h020, 1, 32'h11223344, 4'hF, 0);
        wr(12'h020, 1, 32'h0000AA00, 4'b0010, 0);
        chk("model_merge", model[12'h020], 32'h1122AA44);
        rd(12'h020, 1);
        drain();

        // Full 8-beat read burst.
        wr(12'h100, 8, 32'hA5000100, 4'hF, 0);
        rd(12'h100, 8);
        drain();

        // Write burst with a gap after beat 2.
        wr(12'h200, 4, 32'hC0DE0200, 4'hF, 2);
        rd(12'h200, 4);
        drain();

        // Address wrap at the top of the address space.
        wr(12'hFFE, 4, 32'hE0E0FFE0, 4'hF, 0);
        rd(12'hFFE, 4);
        drain();

        // Reset in the cycle that issues beat 3 of an 8-beat read.
        avs_address    = 12'h100;
        avs_burstcount = 4'd8;
        avs_read       = 1'b1;
        #1;
        exp_q.push_back('{model[12'h100], 2'b00, cyc + 32'd2});
        tick();
        avs_read = 1'b0;
        exp_q.push_back('{model[12'h101], 2'b00, cyc + 32'd2});
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_cs", 32'(ram_chipselect), 32'd0);
        chk("mid_rst_wait", 32'(avs_waitrequest), 32'd1);
        chk("mid_rst_clken", 32'(ram_clken), 32'd0);
        tick();
        reset = 1'b0;
        drain();
        rd(12'h107, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
